// File: rtl/conv11_tile_sched.sv
// Sequencer for the 1x1 conv engine: oc tile -> pixel -> ic tile loops.
// Optional perf counters enabled by defining CONV11_SCHED_PERF_EN.
module conv11_tile_sched #(
   parameter int PIX_W  = 12,
   parameter int TILE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PIX_W-1:0]  cfg_pixels,
   input  logic [TILE_W-1:0] cfg_ic_tiles,
   input  logic [TILE_W-1:0] cfg_oc_tiles,
   output logic              busy,
   output logic              done,
   output logic              err_cfg,
   output logic              wload_req,
   input  logic              wload_ack,
   output logic [TILE_W-1:0] w_oc_idx,
   output logic              in_load_req,
   input  logic              in_load_ack,
   output logic [PIX_W-1:0]  in_pix_idx,
   output logic [TILE_W-1:0] in_ic_idx,
   output logic              mac_start,
   output logic              mac_first,
   input  logic              mac_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pix_idx,
   output logic [TILE_W-1:0] out_oc_idx
`ifdef CONV11_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stall
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_ILOAD,
      S_MAC,
      S_OUT,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   logic [PIX_W-1:0]  pixels_q;
   logic [TILE_W-1:0] ic_tiles_q;
   logic [TILE_W-1:0] oc_tiles_q;
   logic [PIX_W-1:0]  pix_q;
   logic [TILE_W-1:0] ic_q;
   logic [TILE_W-1:0] oc_q;

   logic cfg_ok;
   logic accept;
   logic pix_last;
   logic ic_last;
   logic oc_last;

   assign cfg_ok = (cfg_pixels != '0) && (cfg_ic_tiles != '0) &&
                   (cfg_oc_tiles != '0);
   assign accept = (state_q == S_IDLE) && start && cfg_ok;

   // Latched counts are never zero, so cfg-1 cannot underflow.
   assign pix_last = (pix_q == pixels_q - PIX_W'(1));
   assign ic_last  = (ic_q == ic_tiles_q - TILE_W'(1));
   assign oc_last  = (oc_q == oc_tiles_q - TILE_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_WLOAD;
         end
         S_WLOAD: begin
            if (wload_ack) state_d = S_ILOAD;
         end
         S_ILOAD: begin
            if (in_load_ack) state_d = S_MAC;
         end
         S_MAC: begin
            if (mac_done) state_d = ic_last ? S_OUT : S_ILOAD;
         end
         S_OUT: begin
            if (out_ready) begin
               if (!pix_last)     state_d = S_ILOAD;
               else if (!oc_last) state_d = S_WLOAD;
               else               state_d = S_FIN;
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixels_q   <= '0;
         ic_tiles_q <= '0;
         oc_tiles_q <= '0;
         pix_q      <= '0;
         ic_q       <= '0;
         oc_q       <= '0;
         err_cfg    <= 1'b0;
         mac_start  <= 1'b0;
         mac_first  <= 1'b0;
      end else begin
         err_cfg   <= (state_q == S_IDLE) && start && !cfg_ok;
         mac_start <= (state_q == S_ILOAD) && in_load_ack;
         mac_first <= (state_q == S_ILOAD) && in_load_ack && (ic_q == '0);
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  pixels_q   <= cfg_pixels;
                  ic_tiles_q <= cfg_ic_tiles;
                  oc_tiles_q <= cfg_oc_tiles;
                  pix_q      <= '0;
                  ic_q       <= '0;
                  oc_q       <= '0;
               end
            end
            S_MAC: begin
               if (mac_done) ic_q <= ic_last ? '0 : ic_q + 1'b1;
            end
            S_OUT: begin
               if (out_ready) begin
                  if (pix_last) begin
                     pix_q <= '0;
                     if (!oc_last) oc_q <= oc_q + 1'b1;
                  end else begin
                     pix_q <= pix_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake levels decode straight from state so reset drops them at once.
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FIN);
   assign wload_req   = (state_q == S_WLOAD);
   assign in_load_req = (state_q == S_ILOAD);
   assign out_valid   = (state_q == S_OUT);
   assign w_oc_idx    = oc_q;
   assign in_pix_idx  = pix_q;
   assign in_ic_idx   = ic_q;
   assign out_pix_idx = pix_q;
   assign out_oc_idx  = oc_q;

`ifdef CONV11_SCHED_PERF_EN
   logic req_seen;
   logic stall;

   assign stall = ((state_q == S_OUT) && !out_ready) ||
                  (((state_q == S_WLOAD) || (state_q == S_ILOAD)) &&
                   req_seen);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_seen    <= 1'b0;
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else begin
         // Set once a request has been up a full cycle without its ack.
         req_seen <= ((state_q == S_WLOAD) && !wload_ack) ||
                     ((state_q == S_ILOAD) && !in_load_ack);
         if (accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
         end else begin
            if (busy)  perf_cycles <= perf_cycles + 32'd1;
            if (stall) perf_stall  <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_conv11_tile_sched.sv
// Bench for conv11_tile_sched: random handshake timing vs loop-order model.
module tb_conv11_tile_sched;

   localparam int PIX_W  = 12;
   localparam int TILE_W = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic [PIX_W-1:0]  cfg_pixels;
   logic [TILE_W-1:0] cfg_ic_tiles;
   logic [TILE_W-1:0] cfg_oc_tiles;
   logic              busy;
   logic              done;
   logic              err_cfg;
   logic              wload_req;
   logic              wload_ack;
   logic [TILE_W-1:0] w_oc_idx;
   logic              in_load_req;
   logic              in_load_ack;
   logic [PIX_W-1:0]  in_pix_idx;
   logic [TILE_W-1:0] in_ic_idx;
   logic              mac_start;
   logic              mac_first;
   logic              mac_done;
   logic              out_valid;
   logic              out_ready;
   logic [PIX_W-1:0]  out_pix_idx;
   logic [TILE_W-1:0] out_oc_idx;

   int total = 0;
   int bad   = 0;

   logic [43:0] outs_v;

   conv11_tile_sched #(.PIX_W(PIX_W), .TILE_W(TILE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_pixels   (cfg_pixels),
      .cfg_ic_tiles (cfg_ic_tiles),
      .cfg_oc_tiles (cfg_oc_tiles),
      .busy         (busy),
      .done         (done),
      .err_cfg      (err_cfg),
      .wload_req    (wload_req),
      .wload_ack    (wload_ack),
      .w_oc_idx     (w_oc_idx),
      .in_load_req  (in_load_req),
      .in_load_ack  (in_load_ack),
      .in_pix_idx   (in_pix_idx),
      .in_ic_idx    (in_ic_idx),
      .mac_start    (mac_start),
      .mac_first    (mac_first),
      .mac_done     (mac_done),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pix_idx  (out_pix_idx),
      .out_oc_idx   (out_oc_idx)
   );

   assign outs_v = {busy, done, err_cfg, wload_req, in_load_req,
                    mac_start, mac_first, out_valid, w_oc_idx,
                    in_pix_idx, in_ic_idx, out_pix_idx, out_oc_idx};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit coin();
      return ($urandom & 32'd1) != 0;
   endfunction

   task automatic idle_inputs();
      start       = 1'b0;
      wload_ack   = 1'b0;
      in_load_ack = 1'b0;
      mac_done    = 1'b0;
      out_ready   = 1'b0;
   endtask

   // Runs one layer with random handshake timing and checks the event
   // streams against the nested-loop order oc -> pix -> ic.
   task automatic run_layer(input int px, input int icn, input int ocn,
                            input bit fast, input bit hold,
                            input bit stray, input bit abort);
      int wl_q[$];
      int mac_q[$];
      int out_q[$];
      int ew[$];
      int em[$];
      int eo[$];
      int dones;
      int errs;
      int cyc;
      bit fin;
      bit mac_pend;
      bit held;
      bit resume;
      logic [PIX_W-1:0]  hp;
      logic [TILE_W-1:0] ho;
      dones = 0; errs = 0; cyc = 0;
      fin = 0; mac_pend = 0; held = 0; resume = 0;
      @(negedge clk);
      cfg_pixels   = PIX_W'(px);
      cfg_ic_tiles = TILE_W'(icn);
      cfg_oc_tiles = TILE_W'(ocn);
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_pixels   = PIX_W'($urandom);
      cfg_ic_tiles = TILE_W'($urandom);
      cfg_oc_tiles = TILE_W'($urandom);
      chk("busy_on", busy, 1);
      while (!fin && cyc < 3000) begin
         cyc++;
         if (resume) begin
            resume = 0;
            chk("resume_valid", out_valid, 0);
            chk("resume_prog", in_load_req | wload_req | done, 1);
         end
         if (done) dones++;
         if (err_cfg) errs++;
         if (!busy) fin = 1;
         if (mac_start) begin
            mac_q.push_back(int'(in_pix_idx) * 256 + int'(in_ic_idx) * 2 +
                            int'(mac_first));
            mac_pend = 1;
            if (abort && in_pix_idx == PIX_W'(1)) begin
               idle_inputs();
               #2 rst = 1'b1;
               #1 chk("abort_outs", outs_v, 0);
               @(negedge clk);
               rst = 1'b0;
               @(negedge clk);
               chk("abort_idle", outs_v, 0);
               return;
            end
         end
         idle_inputs();
         if (hold && !held && out_valid) begin
            hp = out_pix_idx;
            ho = out_oc_idx;
            repeat (10) begin
               @(negedge clk);
               chk("hold_valid", out_valid, 1);
               chk("hold_pix", out_pix_idx, hp);
               chk("hold_oc", out_oc_idx, ho);
               chk("hold_noreq", in_load_req, 0);
            end
            out_ready = 1'b1;
            out_q.push_back(int'(hp) * 16 + int'(ho));
            held   = 1;
            resume = 1;
         end else begin
            wload_ack = wload_req && (fast || coin());
            if (!wload_req && stray && coin()) wload_ack = 1'b1;
            if (wload_req && wload_ack) wl_q.push_back(int'(w_oc_idx));
            in_load_ack = in_load_req && (fast || coin());
            if (mac_pend && (fast || coin())) begin
               mac_done = 1'b1;
               mac_pend = 0;
            end else if (stray && in_load_req && coin()) begin
               mac_done = 1'b1;
            end
            out_ready = fast || coin();
            if (out_valid && out_ready)
               out_q.push_back(int'(out_pix_idx) * 16 + int'(out_oc_idx));
            if (stray && busy && !done && coin()) begin
               start        = 1'b1;
               cfg_pixels   = PIX_W'($urandom_range(3, 0));
               cfg_ic_tiles = TILE_W'($urandom_range(3, 0));
               cfg_oc_tiles = TILE_W'($urandom_range(3, 0));
            end
         end
         @(negedge clk);
      end
      idle_inputs();
      chk("finished", fin, 1);
      chk("done_cnt", dones, 1);
      chk("err_in_run", errs, 0);
      chk("busy_off", busy, 0);
      for (int o = 0; o < ocn; o++) begin
         ew.push_back(o);
         for (int p = 0; p < px; p++) begin
            for (int i = 0; i < icn; i++)
               em.push_back(p * 256 + i * 2 + ((i == 0) ? 1 : 0));
            eo.push_back(p * 16 + o);
         end
      end
      chk("n_wload", wl_q.size(), ew.size());
      chk("n_mac", mac_q.size(), em.size());
      chk("n_out", out_q.size(), eo.size());
      for (int k = 0; k < ew.size() && k < wl_q.size(); k++)
         chk("wload_oc", wl_q[k], ew[k]);
      for (int k = 0; k < em.size() && k < mac_q.size(); k++)
         chk("mac_ev", mac_q[k], em[k]);
      for (int k = 0; k < eo.size() && k < out_q.size(); k++)
         chk("out_ev", out_q[k], eo[k]);
   endtask

   task automatic reject(input int px, input int icn, input int ocn);
      logic any;
      @(negedge clk);
      cfg_pixels   = PIX_W'(px);
      cfg_ic_tiles = TILE_W'(icn);
      cfg_oc_tiles = TILE_W'(ocn);
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", err_cfg, 1);
      chk("err_busy", busy, 0);
      any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any = any | err_cfg | busy | wload_req | in_load_req |
               mac_start | out_valid;
      end
      chk("err_quiet", any, 0);
   endtask

   initial begin
      rst = 1'b1;
      cfg_pixels   = '0;
      cfg_ic_tiles = '0;
      cfg_oc_tiles = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst_outs", outs_v, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outs", outs_v, 0);

      run_layer(2, 1, 1, 1, 0, 0, 0);
      run_layer(3, 3, 2, 0, 0, 0, 0);
      run_layer(3, 2, 1, 0, 1, 0, 0);

      reject(3, 0, 2);
      reject(0, 2, 2);
      reject(3, 2, 0);

      run_layer(3, 2, 2, 0, 0, 0, 1);
      run_layer(3, 2, 2, 0, 0, 0, 0);

      run_layer(3, 3, 2, 0, 0, 1, 0);

      repeat (4) begin
         run_layer(int'($urandom_range(5, 1)), int'($urandom_range(3, 1)),
                   int'($urandom_range(3, 1)), 0, 0, 1, 0);
      end

      run_layer(2, 15, 1, 1, 0, 0, 0);
      run_layer(1, 1, 15, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv11_tile_sched.md
Name: conv11_tile_sched

Overview:
Top-level sequencer for the 1x1 convolution engine. It walks output-channel tiles, pixels and input-channel tiles in that loop order. For each step it drives the weight-buffer load, input-buffer load, MAC start/accumulate and output handshakes. It sits between the layer controller (start/config/done) and the conv11 input buffer, weight buffer, MAC array and output writer.

Parameters:
PIX_W, 12, width of pixel count and pixel index
TILE_W, 4, width of ic/oc tile counts and tile indices

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to run a layer; sampled only in IDLE
cfg_pixels  in  PIX_W  pixels per layer (H*W); latched on accepted start
cfg_ic_tiles  in  TILE_W  input-channel tiles; latched on accepted start
cfg_oc_tiles  in  TILE_W  output-channel tiles; latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at layer end
err_cfg  out  1  one-cycle pulse when start is rejected for a zero config field
wload_req  out  1  weight load request, level
wload_ack  in  1  weight buffer finished loading the tile
w_oc_idx  out  TILE_W  oc tile to load
in_load_req  out  1  input buffer load request, level
in_load_ack  in  1  input buffer loaded
in_pix_idx  out  PIX_W  pixel to load
in_ic_idx  out  TILE_W  ic tile to load
mac_start  out  1  one-cycle pulse starting one MAC pass
mac_first  out  1  valid with mac_start: clear accumulator (ic_idx==0)
mac_done  in  1  MAC pass complete pulse
out_valid  out  1  accumulated result ready for writer
out_ready  in  1  writer accepts result
out_pix_idx  out  PIX_W  pixel of the current result
out_oc_idx  out  TILE_W  oc tile of the current result

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, err_cfg, wload_req, in_load_req, mac_start, mac_first, out_valid = 0; index outputs = 0.
- States: IDLE, WLOAD, ILOAD, MAC, OUT, FIN.
- IDLE: start with all cfg fields nonzero -> latch cfg, clear oc/pix/ic counters, busy=1, go WLOAD. If any cfg field is 0 -> err_cfg pulse next cycle, stay IDLE. start outside IDLE is ignored.
- WLOAD: wload_req=1, w_oc_idx=oc. On wload_ack: drop req same edge, go ILOAD.
- ILOAD: in_load_req=1, with in_pix_idx=pix and in_ic_idx=ic. On in_load_ack: go MAC and issue mac_start pulse that cycle (registered). mac_first=(ic==0).
- MAC: wait mac_done. An ack or done in the same cycle as the request is accepted (zero-wait allowed). On mac_done: if ic<ic_tiles-1 -> ic+1, go ILOAD; else ic=0, go OUT.
- OUT: out_valid=1 with out_pix_idx/out_oc_idx stable. Transfer happens on out_valid&&out_ready. On transfer: if pix<pixels-1 -> pix+1, go ILOAD; else pix=0, and if oc<oc_tiles-1 -> oc+1, go WLOAD; else go FIN.
- FIN: done=1 for one cycle, busy=0 on the following edge, return IDLE.
- Wrap: counters compare against latched cfg minus 1 at full width; never exceed cfg-1. cfg inputs may change while busy without effect.
- Stray wload_ack, in_load_ack or mac_done in a state not waiting for it: ignored.
- rst mid-operation: immediate return to reset values. Pending requests drop asynchronously.
- Total mac_start pulses per layer = pixels*ic_tiles*oc_tiles. Out transfers = pixels*oc_tiles. Weight loads = oc_tiles.

Optional Feature:
Macro CONV11_SCHED_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_stall[31:0]. perf_cycles counts cycles while busy. perf_stall counts cycles in OUT with out_ready=0, plus cycles in ILOAD/WLOAD after the first request cycle. Both clear on accepted start and hold after done.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. cfg pixels=2, ic=1, oc=1, all acks/done immediate -> 1 wload, 2 mac_start each with mac_first=1, out pix 0 then 1, done once, busy low after.
2. pixels=3, ic=3, oc=2 -> 18 mac_start; mac_first only on ic==0; 6 outputs in order (oc0:p0..p2, oc1:p0..p2); 2 weight loads with w_oc_idx 0,1.
3. out_ready held low 10 cycles in OUT -> out_valid and indices stable, no new in_load_req; progress resumes on the cycle after out_ready rises.
4. start with cfg_ic_tiles=0 -> err_cfg pulse, busy stays 0, no requests issued.
5. rst asserted while in MAC (pixel 1) -> all outputs 0 immediately; new start runs cleanly from oc=0, pix=0.
6. start pulsed while busy, plus spurious mac_done in ILOAD -> both ignored; output count and order unchanged vs scenario 2.
